// File: rtl/mag_cmp_sched.sv
// mag_cmp_sched
//   One shared 4-bit unsigned magnitude comparator time-multiplexed among four
//   requesters. A round-robin arbiter picks at most one request per cycle. The
//   chosen operands are compared and loaded into a single response register.
//   That register drains over a valid/ready handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : [3:0] per-requester request pending
//   req_a      : [15:0] operand A, requester i in bits [4i+3:4i]
//   req_b      : [15:0] operand B, requester i in bits [4i+3:4i]
//   req_ready  : [3:0] one-hot (or zero) acceptance this cycle
//   rsp_valid  : response register holds a result
//   rsp_id     : [1:0] requester that owns the result
//   rsp_lt/eq/gt : A<B, A==B, A>B for that result (all zero when idle)
//   rsp_ready  : consumer takes the response this cycle
//   done_cnt   : [CNT_W-1:0] completed-response counter, wraps
module mag_cmp_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic [3:0]       req_ready,
  output logic             rsp_valid,
  output logic [1:0]       rsp_id,
  output logic             rsp_lt,
  output logic             rsp_eq,
  output logic             rsp_gt,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int NUM_REQ = 4;

  typedef struct packed {
    logic [1:0] id;
    logic       lt;
    logic       eq;
    logic       gt;
  } rsp_t;

  logic             rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q, rsp_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic       slot_free;
  logic       cand_vld;
  logic [1:0] cand_idx;
  logic       gnt;
  logic [3:0] op_a, op_b;
  logic       rsp_xfer;

  // The response slot can take a new result if it is empty or being drained
  // in this same cycle. The drain-and-refill case keeps one compare per cycle.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign rsp_xfer  = rsp_valid_q && rsp_ready;

  // Round-robin search: first valid requester at ptr, ptr+1, ... (mod 4).
  // The 2-bit sum wraps naturally.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!cand_vld && req_valid[ptr_q + 2'(k)]) begin
        cand_vld = 1'b1;
        cand_idx = ptr_q + 2'(k);
      end
    end
  end

  assign gnt       = cand_vld && slot_free && !rst;
  assign req_ready = gnt ? (4'b0001 << cand_idx) : 4'b0000;

  // Shared comparator operands come from the granted lane only.
  assign op_a = req_a[{cand_idx, 2'b00} +: 4];
  assign op_b = req_b[{cand_idx, 2'b00} +: 4];

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    ptr_d       = ptr_q;
    done_cnt_d  = done_cnt_q + CNT_W'(rsp_xfer);
    if (gnt) begin
      rsp_valid_d = 1'b1;
      rsp_d.id    = cand_idx;
      rsp_d.lt    = op_a <  op_b;
      rsp_d.eq    = op_a == op_b;
      rsp_d.gt    = op_a >  op_b;
      ptr_d       = cand_idx + 2'd1;
    end else if (rsp_xfer) begin
      // Idle outputs read as zero, so clear the payload along with valid.
      rsp_valid_d = 1'b0;
      rsp_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr_q       <= 2'd0;
      done_cnt_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      ptr_q       <= ptr_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_lt    = rsp_q.lt;
  assign rsp_eq    = rsp_q.eq;
  assign rsp_gt    = rsp_q.gt;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_mag_cmp_sched.sv
module tb_mag_cmp_sched;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [15:0]      req_a, req_b;
  logic [3:0]       req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic             rsp_lt, rsp_eq, rsp_gt;
  logic             rsp_ready;
  logic [CNT_W-1:0] done_cnt;

  mag_cmp_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt),
    .rsp_ready(rsp_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: arbiter pointer, response-slot occupancy and the
  // completed-response count.
  logic [1:0]       m_ptr;
  logic             m_vld;
  logic [CNT_W-1:0] m_cnt;
  // Expected responses as {id, lt, eq, gt}, pushed on grant, popped on drain.
  logic [4:0]       sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at the negedge against the model, then advance
  // the model across the posedge. Inputs must be set before the call.
  task automatic step();
    logic       gv;
    logic [1:0] gi, idx;
    logic [3:0] er, a, b;
    @(negedge clk);
    gv = 1'b0;
    gi = 2'd0;
    if (!rst && (!m_vld || rsp_ready)) begin
      for (int k = 0; k < 4; k++) begin
        idx = m_ptr + 2'(k);
        if (!gv && req_valid[idx]) begin
          gv = 1'b1;
          gi = idx;
        end
      end
    end
    er = gv ? (4'b0001 << gi) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
    if (m_vld && sb_q.size() > 0)
      chk("rsp_payload", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'(sb_q[0]));
    else
      chk("rsp_idle_zero", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
    a = req_a[{gi, 2'b00} +: 4];
    b = req_b[{gi, 2'b00} +: 4];
    @(posedge clk);
    if (rst) begin
      m_ptr = 2'd0;
      m_vld = 1'b0;
      m_cnt = '0;
      sb_q.delete();
    end else begin
      if (m_vld && rsp_ready) begin
        void'(sb_q.pop_front());
        m_cnt = m_cnt + CNT_W'(1);
        m_vld = 1'b0;
      end
      if (gv) begin
        sb_q.push_back({gi, a < b, a == b, a > b});
        m_vld = 1'b1;
        m_ptr = gi + 2'd1;
      end
    end
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  logic [3:0] bnd_a[5] = '{4'd0, 4'd15, 4'd0, 4'd15, 4'd7};
  logic [3:0] bnd_b[5] = '{4'd0, 4'd15, 4'd15, 4'd0, 4'd8};
  logic [2:0] bnd_f[5] = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b100};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_ptr = 2'd0; m_vld = 1'b0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held: request must be refused and outputs idle.
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1 chk("rst_ready_zero", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0; req_valid = '0;
    step();

    // Single request: 9 vs 3 -> gt, done_cnt 1 one cycle after response.
    set_op(0, 4'd9, 4'd3); req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 chk("single_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    chk("single_rsp", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'b1_00_001);
    step();
    chk("single_cnt", 32'(done_cnt), 32'd1);

    // Boundary operand pairs through requester 2.
    for (int i = 0; i < 5; i++) begin
      set_op(2, bnd_a[i], bnd_b[i]); req_valid = 4'b0100;
      step();
      chk("bnd_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(bnd_f[i]));
    end
    req_valid = '0;
    step();

    // Fairness: all requesting, pointer was left at 3 -> 3,0,1,2,3,...
    for (int i = 0; i < 4; i++) set_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_id", 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'(3 + i)}));
    end
    req_valid = '0;
    step();

    // Backpressure: hold response 3 cycles, operands change meanwhile.
    set_op(0, 4'd2, 4'd5); req_valid = 4'b0001; rsp_ready = 1'b0;
    step();
    req_valid = 4'b0110; set_op(0, 4'd9, 4'd1);
    set_op(1, 4'd4, 4'd4); set_op(2, 4'd1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'b1_00_100);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_gnt", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();

    // Reset during a held response: discarded, no count, pointer back to 0.
    set_op(2, 4'd3, 4'd3); req_valid = 4'b0100; rsp_ready = 1'b0;
    step();
    req_valid = '0; rsp_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_vld", 32'(rsp_valid), 32'd0);
    chk("rst_mid_cnt", 32'(done_cnt), 32'd0);
    req_valid = 4'b1010;
    #1 chk("rst_mid_gnt", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();

    // Random traffic; model covers arbitration, payload and counter wrap.
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
